// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the four-requester memory port arbiter.
package mem_arb_pkg;
   localparam int NREQ  = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;
   typedef enum logic {CAUSE_NORMAL = 1'b0, CAUSE_TIMEOUT = 1'b1} rel_cause_t;

   function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] i);
      return NREQ'(1) << i;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: index ptr+1 is searched first, ptr itself last.
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] idx
);
   logic [SEL_W-1:0] cand;

   // Walk from lowest to highest priority so the nearest requester overwrites the rest.
   always_comb begin
      any  = 1'b0;
      idx  = ptr;
      cand = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner selection for one shared memory port with valid/ready handshake
// and a bounded wait that forces release when the slave never answers.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [SEL_W-1:0] sel,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [NREQ-1:0]  done,
   output logic             timeout_err,
   output logic             busy
);
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   // Out-of-range parameter sets elaborate this marker scope, visible in the hierarchy.
   if (XLEN < 1 || TIMEOUT < 0 || TIMEOUT > 65535) begin : g_bad_params
   end

   arb_state_t       state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
   logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d;
   logic             mem_valid_q, mem_valid_d, terr_q, terr_d, busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [NREQ-1:0]  pick_req;
   logic [SEL_W-1:0] pick_ptr, pick_idx;
   logic             pick_any, grant, to_hit;
   rel_cause_t       cause;

   // In RELEASE the outgoing owner still holds req until it sees done; mask it out.
   always_comb begin
      pick_req = req;
      pick_ptr = ptr_q;
      if (state_q == RELEASE) begin
         pick_req = req & ~onehot(sel_q);
         pick_ptr = sel_q;
      end
   end

   rr_pick u_pick (
      .req (pick_req),
      .ptr (pick_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      gnt_d       = '0;
      done_d      = '0;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      mem_valid_d = 1'b0;
      terr_d      = 1'b0;
      busy_d      = 1'b0;
      cnt_d       = cnt_q;
      grant       = 1'b0;
      cause       = CAUSE_NORMAL;
      case (state_q)
         IDLE: grant = pick_any;
         BUSY: begin
            if (mem_ready || to_hit) begin
               cause   = mem_ready ? CAUSE_NORMAL : CAUSE_TIMEOUT;
               state_d = RELEASE;
               done_d  = onehot(sel_q);
               terr_d  = (cause == CAUSE_TIMEOUT);
            end else begin
               gnt_d       = gnt_q;
               mem_valid_d = 1'b1;
               busy_d      = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            ptr_d   = sel_q;
            state_d = IDLE;
            grant   = pick_any;
         end
         default: state_d = IDLE;
      endcase
      if (grant) begin
         state_d     = BUSY;
         sel_d       = pick_idx;
         gnt_d       = onehot(pick_idx);
         mem_valid_d = 1'b1;
         busy_d      = 1'b1;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         sel_q       <= '0;
         ptr_q       <= SEL_W'(NREQ - 1);
         mem_valid_q <= 1'b0;
         terr_q      <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         mem_valid_q <= mem_valid_d;
         terr_q      <= terr_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
      end
   end

   assign gnt         = gnt_q;
   assign sel         = sel_q;
   assign mem_valid   = mem_valid_q;
   assign done        = done_q;
   assign timeout_err = terr_q;
   assign busy        = busy_q;
endmodule
